// File: rtl/snn_delay_pkg.sv
// Shared helpers for the delayed-synapse LIF network: weight bit layout,
// ternary weight decode and accumulator sizing.
package snn_delay_pkg;

  localparam int W_NZ   = 1;
  localparam int W_SIGN = 0;

  function automatic int clog2(input int x);
    int r;
    r = 0;
    while ((1 << r) < x) r++;
    return r;
  endfunction

  // Room for a full-scale potential plus M unit contributions of either sign.
  function automatic int sum_w(input int vw, input int m);
    return vw + clog2(m) + 2;
  endfunction

  function automatic logic signed [1:0] w2int(input logic [1:0] w);
    if (!w[W_NZ]) return 2'sd0;
    return w[W_SIGN] ? -2'sd1 : 2'sd1;
  endfunction

endpackage

// File: rtl/snn_delay_layer.sv
// One LIF layer: per-input spike history shared by all N neurons, ternary
// delayed synapses. SNN_SPIKE_COUNT_EN adds saturating per-neuron spike counters.
module snn_delay_layer
  import snn_delay_pkg::*;
#(
  parameter int M  = 8,
  parameter int N  = 8,
  parameter int VW = 6,
  parameter int DW = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              act,
  input  logic [M-1:0]      in_spikes,
  input  logic [N*M*2-1:0]  weights,
  input  logic [N*M*DW-1:0] delays,
  input  logic [VW-1:0]     threshold,
  input  logic [VW-1:0]     decay,
  input  logic [VW-1:0]     refractory_period,
  output logic [N*VW-1:0]   potential,
  output logic [N-1:0]      spikes
`ifdef SNN_SPIKE_COUNT_EN
  ,
  output logic [N*8-1:0]    spike_count
`endif
);

  localparam int DMAX = 2**DW - 1;
  localparam int SW   = sum_w(VW, M);
  localparam logic signed [SW-1:0] VMAX = SW'((2**VW) - 1);

  logic [M-1:0][DMAX-1:0] hist;
  logic [M-1:0][DMAX:0]   taps;

  always_ff @(posedge clk) begin
    if (reset) begin
      hist <= '0;
    end else if (act) begin
      for (int m = 0; m < M; m++) begin
        hist[m][0] <= in_spikes[m];
        for (int d = 1; d < DMAX; d++) hist[m][d] <= hist[m][d-1];
      end
    end
  end

  // Tap 0 is the spike presented on this step; stored history supplies taps 1..DMAX.
  always_comb begin
    taps = '0;
    for (int m = 0; m < M; m++) taps[m] = {hist[m], in_spikes[m]};
  end

  for (genvar n = 0; n < N; n++) begin : g_neu
    logic signed [SW-1:0] syn, leak, u;
    logic signed [1:0]    wi;
    logic [DW-1:0]        dly;
    logic [VW-1:0]        v, rc;
    logic                 spk, fire;

    always_comb begin
      syn = '0;
      wi  = '0;
      dly = '0;
      for (int m = 0; m < M; m++) begin
        wi  = w2int(weights[(n*M+m)*2 +: 2]);
        dly = delays[(n*M+m)*DW +: DW];
        if (taps[m][dly]) syn = syn + {{(SW-2){wi[1]}}, wi};
      end
      leak = SW'(v) - SW'(decay);
      if (leak < 0) leak = '0;
      u = leak + syn;
      if (u < 0) u = '0;
      else if (u > VMAX) u = VMAX;
    end

    assign fire = (u >= SW'(threshold));

    always_ff @(posedge clk) begin
      if (reset) begin
        v   <= '0;
        rc  <= '0;
        spk <= 1'b0;
      end else if (act) begin
        if (rc != '0) begin
          rc  <= rc - VW'(1);
          v   <= '0;
          spk <= 1'b0;
        end else if (fire) begin
          spk <= 1'b1;
          v   <= '0;
          rc  <= refractory_period;
        end else begin
          spk <= 1'b0;
          v   <= u[VW-1:0];
        end
      end
    end

    assign potential[n*VW +: VW] = v;
    assign spikes[n]             = spk;

`ifdef SNN_SPIKE_COUNT_EN
    logic [7:0] cnt;
    always_ff @(posedge clk) begin
      if (reset) cnt <= '0;
      else if (act && rc == '0 && fire && cnt != 8'hFF) cnt <= cnt + 8'd1;
    end
    assign spike_count[n*8 +: 8] = cnt;
`endif
  end

endmodule

// File: rtl/snn_delay_net_param.sv
// Two-layer delayed-synapse LIF network top: slices packed config buses and
// chains two layers. SNN_SPIKE_COUNT_EN exposes per-neuron spike counters.
module snn_delay_net_param
  import snn_delay_pkg::*;
#(
  parameter int M1 = 8,
  parameter int N1 = 8,
  parameter int N2 = 2,
  parameter int VW = 6,
  parameter int DW = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        step,
  input  logic [M1-1:0]               input_spikes,
  input  logic [(N1*M1+N2*N1)*2-1:0]  weights,
  input  logic [(N1*M1+N2*N1)*DW-1:0] delays,
  input  logic [VW-1:0]               threshold,
  input  logic [VW-1:0]               decay,
  input  logic [VW-1:0]               refractory_period,
  output logic [(N1+N2)*VW-1:0]       membrane_potential_out,
  output logic [N1-1:0]               output_spikes_layer1,
  output logic [N2-1:0]               output_spikes
`ifdef SNN_SPIKE_COUNT_EN
  ,
  output logic [(N1+N2)*8-1:0]        spike_count
`endif
);

  localparam int NW1 = N1 * M1;
  localparam int NW2 = N2 * N1;

  logic act;
  assign act = enable & step;

  snn_delay_layer #(.M(M1), .N(N1), .VW(VW), .DW(DW)) u_l1 (
    .clk               (clk),
    .reset             (reset),
    .act               (act),
    .in_spikes         (input_spikes),
    .weights           (weights[NW1*2-1:0]),
    .delays            (delays[NW1*DW-1:0]),
    .threshold         (threshold),
    .decay             (decay),
    .refractory_period (refractory_period),
    .potential         (membrane_potential_out[N1*VW-1:0]),
    .spikes            (output_spikes_layer1)
`ifdef SNN_SPIKE_COUNT_EN
    ,
    .spike_count       (spike_count[N1*8-1:0])
`endif
  );

  // Layer 2 sees layer-1's registered spikes, hence one extra step of latency.
  snn_delay_layer #(.M(N1), .N(N2), .VW(VW), .DW(DW)) u_l2 (
    .clk               (clk),
    .reset             (reset),
    .act               (act),
    .in_spikes         (output_spikes_layer1),
    .weights           (weights[(NW1+NW2)*2-1:NW1*2]),
    .delays            (delays[(NW1+NW2)*DW-1:NW1*DW]),
    .threshold         (threshold),
    .decay             (decay),
    .refractory_period (refractory_period),
    .potential         (membrane_potential_out[(N1+N2)*VW-1:N1*VW]),
    .spikes            (output_spikes)
`ifdef SNN_SPIKE_COUNT_EN
    ,
    .spike_count       (spike_count[(N1+N2)*8-1:N1*8])
`endif
  );

endmodule

// File: tb/tb_snn_delay_net_param.sv
// Bench for snn_delay_net_param: directed scenarios plus random stepping
// against a step-history reference model. Honours SNN_SPIKE_COUNT_EN.
module tb_snn_delay_net_param;

  localparam int M1 = 8, N1 = 8, N2 = 2, VW = 6, DW = 3;
  localparam int NS = N1*M1 + N2*N1, L2 = N1*M1, NT = N1 + N2;
  localparam int DMAX = 2**DW - 1, VMAX = 2**VW - 1;

  logic                 clk = 1'b0;
  logic                 reset, enable, step;
  logic [M1-1:0]        input_spikes;
  logic [NS*2-1:0]      weights;
  logic [NS*DW-1:0]     delays;
  logic [VW-1:0]        threshold, decay, refractory_period;
  logic [NT*VW-1:0]     mem;
  logic [N1-1:0]        spk1;
  logic [N2-1:0]        spk2;
`ifdef SNN_SPIKE_COUNT_EN
  logic [NT*8-1:0]      spike_count;
`endif

  snn_delay_net_param #(.M1(M1), .N1(N1), .N2(N2), .VW(VW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .step(step),
    .input_spikes(input_spikes), .weights(weights), .delays(delays),
    .threshold(threshold), .decay(decay), .refractory_period(refractory_period),
    .membrane_potential_out(mem), .output_spikes_layer1(spk1), .output_spikes(spk2)
`ifdef SNN_SPIKE_COUNT_EN
    , .spike_count(spike_count)
`endif
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: neuron state plus a list of past step inputs (newest first).
  int mv[NT], mr[NT], ms[NT], mc[NT];
  logic [M1-1:0] h1[$];
  logic [N1-1:0] h2[$];

  function automatic int wv(input int idx);
    logic [1:0] b;
    b = weights[idx*2 +: 2];
    if (b == 2'b10) return 1;
    if (b == 2'b11) return -1;
    return 0;
  endfunction

  function automatic int dv(input int idx);
    return int'(delays[idx*DW +: DW]);
  endfunction

  task automatic neuron(input int n, input int syn);
    int u;
    if (mr[n] > 0) begin
      mr[n]--; mv[n] = 0; ms[n] = 0;
    end else begin
      u = mv[n] - int'(decay);
      if (u < 0) u = 0;
      u += syn;
      if (u < 0) u = 0;
      if (u > VMAX) u = VMAX;
      if (u >= int'(threshold)) begin
        ms[n] = 1; mv[n] = 0; mr[n] = int'(refractory_period);
        if (mc[n] < 255) mc[n]++;
      end else begin
        ms[n] = 0; mv[n] = u;
      end
    end
  endtask

  task automatic model_reset();
    for (int n = 0; n < NT; n++) begin mv[n] = 0; mr[n] = 0; ms[n] = 0; mc[n] = 0; end
    h1.delete();
    h2.delete();
  endtask

  task automatic model_step();
    logic [N1-1:0] prev1;
    int syn, idx, d;
    for (int n = 0; n < N1; n++) prev1[n] = (ms[n] != 0);
    h1.push_front(input_spikes);
    h2.push_front(prev1);
    if (h1.size() > DMAX + 1) void'(h1.pop_back());
    if (h2.size() > DMAX + 1) void'(h2.pop_back());
    for (int n = 0; n < N1; n++) begin
      syn = 0;
      for (int m = 0; m < M1; m++) begin
        idx = n*M1 + m; d = dv(idx);
        if (d < h1.size() && h1[d][m]) syn += wv(idx);
      end
      neuron(n, syn);
    end
    for (int n = 0; n < N2; n++) begin
      syn = 0;
      for (int m = 0; m < N1; m++) begin
        idx = L2 + n*N1 + m; d = dv(idx);
        if (d < h2.size() && h2[d][m]) syn += wv(idx);
      end
      neuron(N1 + n, syn);
    end
  endtask

  task automatic check_model(input string tag);
    logic [NT*VW-1:0] em;
    logic [N1-1:0] e1;
    logic [N2-1:0] e2;
    for (int n = 0; n < NT; n++) em[n*VW +: VW] = VW'(mv[n]);
    for (int n = 0; n < N1; n++) e1[n] = (ms[n] != 0);
    for (int n = 0; n < N2; n++) e2[n] = (ms[N1+n] != 0);
    chk({tag, "/v"}, 64'(mem), 64'(em));
    chk({tag, "/s1"}, 64'(spk1), 64'(e1));
    chk({tag, "/s2"}, 64'(spk2), 64'(e2));
`ifdef SNN_SPIKE_COUNT_EN
    for (int n = 0; n < NT; n++) chk({tag, "/cnt"}, 64'(spike_count[n*8 +: 8]), 64'(mc[n]));
`endif
  endtask

  task automatic tick(input string tag, input logic e, input logic s, input logic r);
    enable = e; step = s; reset = r;
    @(posedge clk);
    if (r) model_reset();
    else if (e && s) model_step();
    @(negedge clk);
    step = 1'b0; reset = 1'b0;
    check_model(tag);
  endtask

  task automatic do_step(input string tag);
    tick(tag, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic set_w(input int idx, input logic [1:0] w);
    weights[idx*2 +: 2] = w;
  endtask

  task automatic base_cfg(input int thr, input int refr);
    weights = '0; delays = '0; input_spikes = '0;
    threshold = VW'(thr); decay = '0; refractory_period = VW'(refr);
  endtask

  function automatic logic [VW-1:0] vof(input int n);
    return mem[n*VW +: VW];
  endfunction

  initial begin
    reset = 1'b1; enable = 1'b0; step = 1'b0;
    base_cfg(1, 0);
    model_reset();
    @(negedge clk);
    tick("rst", 1'b0, 1'b0, 1'b1);
    chk("reset_v", 64'(mem), 64'd0);
    chk("reset_s", 64'({spk2, spk1}), 64'd0);

    // 1: single pulse, delay 0
    base_cfg(1, 0); set_w(0, 2'b10);
    tick("t1r", 1'b0, 1'b0, 1'b1);
    input_spikes = 8'h01;
    do_step("t1");
    chk("t1_spike", 64'(spk1[0]), 64'd1);
    chk("t1_v0", 64'(vof(0)), 64'd0);

    // 2: delay 3
    base_cfg(1, 0); set_w(0, 2'b10); delays[DW-1:0] = 3'd3;
    tick("t2r", 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      input_spikes = (k == 0) ? 8'h01 : 8'h00;
      do_step("t2");
      chk("t2_spike", 64'(spk1[0]), (k == 3) ? 64'd1 : 64'd0);
    end

    // 3: saturation and no underflow
    base_cfg(63, 0);
    for (int m = 0; m < M1; m++) set_w(m, 2'b10);
    tick("t3r", 1'b0, 1'b0, 1'b1);
    input_spikes = 8'hFF;
    for (int k = 1; k <= 7; k++) begin
      do_step("t3");
      chk("t3_climb", 64'(vof(0)), 64'(8*k));
      chk("t3_nospk", 64'(spk1[0]), 64'd0);
    end
    do_step("t3");
    chk("t3_sat_spike", 64'(spk1[0]), 64'd1);
    for (int m = 0; m < M1; m++) set_w(m, 2'b11);
    tick("t3nr", 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      do_step("t3n");
      chk("t3_neg_v", 64'(vof(0)), 64'd0);
    end

    // 4: refractory period 2
    base_cfg(1, 2); set_w(0, 2'b10);
    tick("t4r", 1'b0, 1'b0, 1'b1);
    input_spikes = 8'h01;
    for (int k = 0; k < 4; k++) begin
      do_step("t4");
      chk("t4_spike", 64'(spk1[0]), (k == 0 || k == 3) ? 64'd1 : 64'd0);
      chk("t4_v0", 64'(vof(0)), 64'd0);
    end

    // 5: layer-2 one-step latency
    base_cfg(1, 0); set_w(0, 2'b10); set_w(L2, 2'b10);
    tick("t5r", 1'b0, 1'b0, 1'b1);
    input_spikes = 8'h01;
    do_step("t5");
    chk("t5_l1", 64'(spk1[0]), 64'd1);
    chk("t5_l2_early", 64'(spk2[0]), 64'd0);
    input_spikes = 8'h00;
    do_step("t5");
    chk("t5_l2", 64'(spk2[0]), 64'd1);

    // 6: reset kills in-flight spikes; enable=0 freezes
    base_cfg(1, 0); set_w(0, 2'b10); delays[DW-1:0] = 3'd3;
    tick("t6r", 1'b0, 1'b0, 1'b1);
    input_spikes = 8'h01;
    do_step("t6");
    input_spikes = 8'h00;
    do_step("t6");
    tick("t6rs", 1'b1, 1'b1, 1'b1);
    chk("t6_rst_v", 64'(mem), 64'd0);
    chk("t6_rst_s", 64'({spk2, spk1}), 64'd0);
    for (int k = 0; k < 6; k++) begin
      do_step("t6");
      chk("t6_never", 64'(spk1[0]), 64'd0);
    end
    base_cfg(63, 0);
    for (int m = 0; m < M1; m++) set_w(m, 2'b10);
    tick("t6fr", 1'b0, 1'b0, 1'b1);
    input_spikes = 8'hFF;
    do_step("t6f"); do_step("t6f");
    for (int k = 0; k < 4; k++) begin
      input_spikes = 8'($urandom);
      tick("t6frz", (k % 2) == 1, (k % 2) == 0, 1'b0);
      chk("t6_frozen", 64'(vof(0)), 64'd16);
    end

`ifdef SNN_SPIKE_COUNT_EN
    base_cfg(0, 0);
    tick("cntr", 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 300; k++) do_step("cnt");
    chk("cnt_sat", 64'(spike_count[7:0]), 64'd255);
`endif

    // Random phases
    for (int ph = 0; ph < 6; ph++) begin
      for (int i = 0; i < NS*2; i++) weights[i] = 1'($urandom);
      for (int i = 0; i < NS*DW; i++) delays[i] = 1'($urandom);
      threshold = VW'($urandom_range(0, 12));
      decay = VW'($urandom_range(0, 3));
      refractory_period = VW'($urandom_range(0, 3));
      tick("rndr", 1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 80; k++) begin
        input_spikes = 8'($urandom);
        tick("rnd", ($urandom % 8) != 0, ($urandom % 4) != 0, ($urandom % 60) == 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
